// File: rtl/psum_accum_stream_if.sv
// Stream bundle between the PE array, the partial-sum accumulator and the output DMA.
// The slave side is the accumulator; the master side is its environment.
interface psum_accum_stream_if #(
   parameter int DATA_W = 32
);
   logic              s_psum_valid;
   logic [DATA_W-1:0] s_psum_data;
   logic              s_psum_ready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;

   modport master (
      output s_psum_valid, s_psum_data, m_axis_tready,
      input  s_psum_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

   modport slave (
      input  s_psum_valid, s_psum_data, m_axis_tready,
      output s_psum_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/psum_accum_stream.sv
// Accumulates per-channel partial-sum rows (bias folded in on channel 0), then saturates,
// applies optional ReLU and streams each finished row out over AXI-Stream.
module psum_accum_stream #(
   parameter int DATA_W      = 32,
   parameter int MAX_ROW_LEN = 256,
   parameter int MAX_ROWS    = 256,
   parameter int MAX_CH      = 512
) (
   input  logic                             clk,
   input  logic                             Reset,
   input  logic                             start,
   input  logic [$clog2(MAX_ROW_LEN+1)-1:0] cfg_row_len,
   input  logic [$clog2(MAX_ROWS+1)-1:0]    cfg_num_rows,
   input  logic [$clog2(MAX_CH+1)-1:0]      cfg_num_ch,
   input  logic                             cfg_relu,
   input  logic [DATA_W-1:0]                bias_data,
   psum_accum_stream_if.slave               bus,
   output logic                             busy,
   output logic                             done,
   output logic                             sat_flag
);
   localparam int RL_W  = $clog2(MAX_ROW_LEN+1);
   localparam int RW_W  = $clog2(MAX_ROWS+1);
   localparam int CH_W  = $clog2(MAX_CH+1);
   localparam int IDX_W = (MAX_ROW_LEN > 1) ? $clog2(MAX_ROW_LEN) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCUM  = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic [1:0]               state;
   logic [RL_W-1:0]          row_len_q;
   logic [RW_W-1:0]          num_rows_q;
   logic [CH_W-1:0]          num_ch_q;
   logic                     relu_q;
   logic signed [DATA_W-1:0] bias_q;
   logic [RL_W-1:0]          px;
   logic [CH_W-1:0]          ch;
   logic [RW_W-1:0]          row;
   logic signed [DATA_W-1:0] tdata_q;
   logic                     tvalid_q;
   logic                     tlast_q;
   logic                     sat_q;
   logic signed [DATA_W-1:0] row_buf [MAX_ROW_LEN];

   logic                     cfg_ok;
   logic                     first_ch;
   logic                     last_ch;
   logic                     last_px;
   logic                     last_row;
   logic                     ready;
   logic                     accept;
   logic [IDX_W-1:0]         px_idx;
   logic signed [DATA_W-1:0] src;
   logic signed [DATA_W:0]   sum;
   logic                     ovf;
   logic signed [DATA_W-1:0] sat_val;
   logic signed [DATA_W-1:0] out_val;

   assign cfg_ok = (cfg_row_len  != '0) && (cfg_row_len  <= RL_W'(MAX_ROW_LEN)) &&
                   (cfg_num_rows != '0) && (cfg_num_rows <= RW_W'(MAX_ROWS)) &&
                   (cfg_num_ch   != '0) && (cfg_num_ch   <= CH_W'(MAX_CH));

   assign first_ch = (ch  == '0);
   assign last_ch  = (ch  == num_ch_q   - CH_W'(1));
   assign last_px  = (px  == row_len_q  - RL_W'(1));
   assign last_row = (row == num_rows_q - RW_W'(1));

   // Last-channel beats need a free (or draining) output register; earlier channels never stall.
   assign ready  = (state == S_ACCUM) && (!last_ch || !tvalid_q || bus.m_axis_tready);
   assign accept = bus.s_psum_valid && ready;

   // Channel 0 starts from the bias, so stale buffer contents are never read.
   assign px_idx  = px[IDX_W-1:0];
   assign src     = first_ch ? bias_q : row_buf[px_idx];
   assign sum     = {src[DATA_W-1], src} + {bus.s_psum_data[DATA_W-1], bus.s_psum_data};
   assign ovf     = sum[DATA_W] ^ sum[DATA_W-1];
   assign sat_val = ovf ? (sum[DATA_W] ? SAT_MIN : SAT_MAX) : sum[DATA_W-1:0];
   assign out_val = (relu_q && sat_val[DATA_W-1]) ? '0 : sat_val;

   assign bus.s_psum_ready  = ready;
   assign bus.m_axis_tdata  = tdata_q;
   assign bus.m_axis_tvalid = tvalid_q;
   assign bus.m_axis_tlast  = tlast_q;
   assign busy              = (state == S_ACCUM) || (state == S_DRAIN);
   assign done              = (state == S_FINISH);
   assign sat_flag          = sat_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state      <= S_IDLE;
         row_len_q  <= '0;
         num_rows_q <= '0;
         num_ch_q   <= '0;
         relu_q     <= 1'b0;
         bias_q     <= '0;
         px         <= '0;
         ch         <= '0;
         row        <= '0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && cfg_ok) begin
                  row_len_q  <= cfg_row_len;
                  num_rows_q <= cfg_num_rows;
                  num_ch_q   <= cfg_num_ch;
                  relu_q     <= cfg_relu;
                  bias_q     <= bias_data;
                  px         <= '0;
                  ch         <= '0;
                  row        <= '0;
                  sat_q      <= 1'b0;
                  state      <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  if (ovf) sat_q <= 1'b1;
                  if (!last_px) begin
                     px <= px + RL_W'(1);
                  end else begin
                     px <= '0;
                     if (!last_ch) begin
                        ch <= ch + CH_W'(1);
                     end else begin
                        ch <= '0;
                        if (!last_row) begin
                           row <= row + RW_W'(1);
                        end else begin
                           row   <= '0;
                           state <= S_DRAIN;
                        end
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (tvalid_q && bus.m_axis_tready && tlast_q) state <= S_FINISH;
            end
            default: state <= S_IDLE;
         endcase

         // One-deep output register: a new load wins over a same-cycle handshake.
         if (accept && last_ch) begin
            tvalid_q <= 1'b1;
            tdata_q  <= out_val;
            tlast_q  <= last_px && last_row;
         end else if (bus.m_axis_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end
      end
   end

   // NOTE: the row buffer has no reset; channel 0 always rewrites every entry it later reads.
   always_ff @(posedge clk) begin
      if (Reset && accept && !last_ch) row_buf[px_idx] <= sat_val;
   end
endmodule

// File: tb/tb_psum_accum_stream.sv
// Scoreboard bench for psum_accum_stream at DATA_W=8: a loop model pushes expected pixels,
// a negedge monitor pops and compares them as the output stream handshakes.
module tb_psum_accum_stream;
   localparam int DW   = 8;
   localparam int MRL  = 8;
   localparam int MRW  = 4;
   localparam int MCH  = 4;
   localparam int RL_W = $clog2(MRL+1);
   localparam int RW_W = $clog2(MRW+1);
   localparam int CH_W = $clog2(MCH+1);
   localparam int MAXV = (1 << (DW-1)) - 1;
   localparam int MINV = -(1 << (DW-1));

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic            clk = 1'b0;
   logic            Reset = 1'b0;
   logic            start = 1'b0;
   logic [RL_W-1:0] cfg_row_len = '0;
   logic [RW_W-1:0] cfg_num_rows = '0;
   logic [CH_W-1:0] cfg_num_ch = '0;
   logic            cfg_relu = 1'b0;
   logic [DW-1:0]   bias_data = '0;
   logic            busy;
   logic            done;
   logic            sat_flag;

   psum_accum_stream_if #(.DATA_W(DW)) bus ();

   psum_accum_stream #(
      .DATA_W(DW), .MAX_ROW_LEN(MRL), .MAX_ROWS(MRW), .MAX_CH(MCH)
   ) u_dut (
      .clk          (clk),
      .Reset        (Reset),
      .start        (start),
      .cfg_row_len  (cfg_row_len),
      .cfg_num_rows (cfg_num_rows),
      .cfg_num_ch   (cfg_num_ch),
      .cfg_relu     (cfg_relu),
      .bias_data    (bias_data),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .sat_flag     (sat_flag)
   );

   always #5 clk = ~clk;

   exp_t          exp_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            out_cnt = 0;
   int            acc_cnt = 0;
   int            done_cnt = 0;
   int            tr_mode = 0;
   logic          tb_last_ch = 1'b0;
   logic          stalled = 1'b0;
   logic [DW-1:0] held_data = '0;
   logic          held_last = 1'b0;
   int            rb;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   initial begin
      int cyc = 0;
      bus.m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         bus.m_axis_tready = (tr_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!Reset) begin
         stalled = 1'b0;
      end else begin
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            out_cnt++;
            check("out_pending", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("tdata", longint'($signed(bus.m_axis_tdata)), longint'($signed(e.data)));
               check("tlast", bus.m_axis_tlast, e.last);
            end
         end
         if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
            if (stalled) begin
               check("hold_tdata", bus.m_axis_tdata, held_data);
               check("hold_tlast", bus.m_axis_tlast, held_last);
            end
            stalled   = 1'b1;
            held_data = bus.m_axis_tdata;
            held_last = bus.m_axis_tlast;
            if (tb_last_ch && busy) check("ready_in_stall", bus.s_psum_ready, 0);
         end else begin
            stalled = 1'b0;
         end
         if (bus.s_psum_valid && bus.s_psum_ready) acc_cnt++;
         if (done) done_cnt++;
      end
   end

   // kind: 0 -> psum = px+1, 1 -> constant cpsum, 2 -> random. abort_at > 0 resets mid-map.
   task automatic run_map(input int rl, input int rows, input int nch, input int relu,
                          input int bias, input int kind, input int cpsum, input int mode,
                          input int inject_at, input int abort_at);
      int   acc[MRL];
      int   beat = 0;
      int   acc_base, out_base, done_base, w, psum, s;
      bit   exp_sat = 1'b0;
      exp_t e;
      tr_mode = mode;
      @(posedge clk);
      #1;
      cfg_row_len  = RL_W'(rl);
      cfg_num_rows = RW_W'(rows);
      cfg_num_ch   = CH_W'(nch);
      cfg_relu     = relu[0];
      bias_data    = DW'(bias);
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      acc_base = acc_cnt;
      out_base = out_cnt;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < nch; c++) begin
            for (int p = 0; p < rl; p++) begin
               if (abort_at != 0 && beat == abort_at) begin
                  bus.s_psum_valid = 1'b0;
                  tb_last_ch = 1'b0;
                  done_base = done_cnt;
                  Reset = 1'b0;
                  @(posedge clk);
                  #1;
                  check("abort_tvalid", bus.m_axis_tvalid, 0);
                  check("abort_busy", busy, 0);
                  check("abort_ready", bus.s_psum_ready, 0);
                  check("abort_tdata", bus.m_axis_tdata, 0);
                  check("abort_sat", sat_flag, 0);
                  Reset = 1'b1;
                  exp_q.delete();
                  repeat (6) @(posedge clk);
                  #1;
                  check("abort_no_done", done_cnt, done_base);
                  check("abort_idle_busy", busy, 0);
                  return;
               end
               case (kind)
                  0:       psum = p + 1;
                  1:       psum = cpsum;
                  default: psum = int'($urandom_range(0, 80)) - 40;
               endcase
               s = (c == 0) ? bias + psum : acc[p] + psum;
               if (s > MAXV) begin s = MAXV; exp_sat = 1'b1; end
               else if (s < MINV) begin s = MINV; exp_sat = 1'b1; end
               if (c == nch - 1) begin
                  if (relu != 0 && s < 0) s = 0;
                  e.data = s[DW-1:0];
                  e.last = (r == rows - 1) && (p == rl - 1);
                  exp_q.push_back(e);
               end else begin
                  acc[p] = s;
               end
               bus.s_psum_valid = 1'b1;
               bus.s_psum_data  = psum[DW-1:0];
               tb_last_ch       = (c == nch - 1);
               w = 0;
               while (1) begin
                  @(negedge clk);
                  if (bus.s_psum_ready) break;
                  w++;
                  if (w >= 50) begin
                     check("psum_ready_timeout", w, 0);
                     bus.s_psum_valid = 1'b0;
                     tb_last_ch = 1'b0;
                     return;
                  end
               end
               @(posedge clk);
               #1;
               start = 1'b0;
               beat++;
               if (c == nch - 1) check("out_latency", bus.m_axis_tvalid, 1);
               if (inject_at != 0 && beat == inject_at) begin
                  cfg_row_len  = RL_W'(1);
                  cfg_num_rows = RW_W'(1);
                  cfg_num_ch   = CH_W'(1);
                  start        = 1'b1;
               end
            end
         end
      end
      bus.s_psum_valid = 1'b0;
      tb_last_ch = 1'b0;
      start = 1'b0;
      w = 0;
      while (!done && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("done_seen", done, 1);
      check("busy_at_done", busy, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      check("psum_beats", acc_cnt - acc_base, rl * rows * nch);
      check("out_beats", out_cnt - out_base, rl * rows);
      check("sat_flag", sat_flag, exp_sat);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      exp_q.delete();
   endtask

   initial begin
      bus.s_psum_valid = 1'b0;
      bus.s_psum_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      Reset = 1'b1;
      @(negedge clk);
      check("rst_tvalid", bus.m_axis_tvalid, 0);
      check("rst_tlast", bus.m_axis_tlast, 0);
      check("rst_tdata", bus.m_axis_tdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sat", sat_flag, 0);
      check("rst_ready", bus.s_psum_ready, 0);

      run_map(4, 1, 1, 0, 10, 0, 0, 0, 0, 0);
      run_map(3, 2, 3, 0, -5, 0, 0, 0, 0, 0);
      run_map(3, 2, 3, 0, -5, 0, 0, 1, 0, 0);
      run_map(3, 2, 3, 0, -5, 0, 0, 0, 5, 0);
      run_map(1, 1, 2, 0, 100, 1, 100, 0, 0, 0);
      run_map(1, 1, 2, 1, -100, 1, -100, 0, 0, 0);

      @(posedge clk);
      #1;
      cfg_row_len  = RL_W'(2);
      cfg_num_rows = RW_W'(1);
      cfg_num_ch   = '0;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("illegal_start_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check("illegal_start_idle", busy, 0);
      check("illegal_start_ready", bus.s_psum_ready, 0);

      rb = int'($urandom_range(0, 60)) - 30;
      run_map(MRL, MRW, MCH, 1, rb, 2, 0, 1, 0, 0);
      run_map(3, 2, 2, 0, 7, 0, 0, 0, 0, 8);
      run_map(3, 1, 2, 0, 3, 0, 0, 0, 0, 0);
      run_map(3, 2, 2, 0, -2, 2, 0, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end
endmodule
